// File: rtl/spi_slave_stream.sv
// spi_slave_stream: clock-domain SPI slave with RX/TX FIFOs for full-duplex back-to-back word streaming
module spi_slave_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int RX_DEPTH = 64,
    parameter int TX_DEPTH = 16,
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE = '1
) (
    input  logic clock,
    input  logic reset,
    input  logic spi_clk,
    input  logic spi_cs,
    input  logic mosi,
    output logic miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic rx_valid,
    input  logic rx_ready,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic tx_wr,
    output logic tx_full,
    output logic [$clog2(TX_DEPTH):0] tx_level,
    input  logic status_clear,
    output logic rx_overrun,
    output logic tx_underrun,
    output logic frame_done,
    output logic frame_abort,
    output logic debug_word
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    logic [SYNC_STAGES-1:0] clk_s, cs_s, mosi_s;
    logic clk_q, cs_q;
    logic [CW-1:0] cnt;
    logic [DATA_WIDTH-2:0] rx_sr;
    logic [DATA_WIDTH-1:0] tx_sr, rx_word;
    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [TAW-1:0] tx_wp, tx_rp;
    logic sclk, scs, smosi, sample, shift, cs_fall, cs_rise, last_bit, rx_full;
    logic rx_push_req, rx_push, rx_pop, tx_load, tx_pop, tx_push;
    always_comb begin
        sclk = clk_s[SYNC_STAGES-1];
        scs = cs_s[SYNC_STAGES-1];
        smosi = mosi_s[SYNC_STAGES-1];
        sample = ~scs & ((CPOL ^ CPHA) ? (~sclk & clk_q) : (sclk & ~clk_q));
        shift = ~scs & ((CPOL ^ CPHA) ? (sclk & ~clk_q) : (~sclk & clk_q));
        cs_fall = ~scs & cs_q;
        cs_rise = scs & ~cs_q;
        last_bit = (cnt == CW'(DATA_WIDTH - 1));
        rx_word = {rx_sr, smosi};
        rx_full = (rx_level == (RAW+1)'(RX_DEPTH));
        rx_pop = rx_ready & rx_valid;
        rx_push_req = sample & last_bit;
        rx_push = rx_push_req & (~rx_full | rx_pop);
        tx_load = (cs_fall & ~CPHA) | (shift & (cnt == '0));
        tx_pop = tx_load & (tx_level != '0);
        tx_push = tx_wr & (~tx_full | tx_pop);
    end
    assign rx_valid = (rx_level != '0);
    assign rx_data = rx_valid ? rx_mem[rx_rp] : '0;
    assign tx_full = (tx_level == (TAW+1)'(TX_DEPTH));
    assign miso = scs ? 1'bz : tx_sr[DATA_WIDTH-1];
    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wp] <= rx_word;
        if (tx_push) tx_mem[tx_wp] <= tx_data;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s <= {SYNC_STAGES{CPOL}};
            cs_s <= '1;
            mosi_s <= '0;
            clk_q <= CPOL;
            cs_q <= 1'b1;
            cnt <= '0;
            rx_sr <= '0;
            tx_sr <= TX_IDLE;
            rx_wp <= '0;
            rx_rp <= '0;
            rx_level <= '0;
            tx_wp <= '0;
            tx_rp <= '0;
            tx_level <= '0;
            rx_overrun <= 1'b0;
            tx_underrun <= 1'b0;
            frame_done <= 1'b0;
            frame_abort <= 1'b0;
            debug_word <= 1'b0;
        end else begin
            clk_s <= {clk_s[SYNC_STAGES-2:0], spi_clk};
            cs_s <= {cs_s[SYNC_STAGES-2:0], spi_cs};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
            clk_q <= sclk;
            cs_q <= scs;
            frame_done <= cs_rise;
            frame_abort <= cs_rise & (cnt != '0);
            if (cs_rise | cs_fall) cnt <= '0;
            else if (sample) cnt <= last_bit ? '0 : cnt + 1'b1;
            if (sample) rx_sr <= rx_word[DATA_WIDTH-2:0];
            if (tx_load) tx_sr <= tx_pop ? tx_mem[tx_rp] : TX_IDLE;
            else if (shift) tx_sr <= tx_sr << 1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            if (rx_push != rx_pop) rx_level <= rx_push ? rx_level + 1'b1 : rx_level - 1'b1;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) tx_rp <= tx_rp + 1'b1;
            if (tx_push != tx_pop) tx_level <= tx_push ? tx_level + 1'b1 : tx_level - 1'b1;
            rx_overrun <= (rx_push_req & ~rx_push) | (rx_overrun & ~status_clear);
            tx_underrun <= (tx_load & ~tx_pop) | (tx_underrun & ~status_clear);
            debug_word <= debug_word ^ rx_push;
        end
    end
endmodule

// File: tb/tb_spi_slave_stream.sv
// tb_spi_slave_stream: scoreboard bench driving one slave per SPI mode from a bit-banged master
module tb_spi_slave_stream;
    localparam int H = 8;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    logic [3:0] sclk, cs, mosi, rx_ready, tx_wr, status_clear;
    logic [7:0] tx_data [4];
    wire [3:0] miso, rx_valid, tx_full, rx_overrun, tx_underrun, frame_done, frame_abort, debug_word;
    wire [7:0] rx_data [4];
    wire [2:0] rx_level [4];
    wire [2:0] tx_level [4];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0, abort_cnt = 0, both_cnt = 0, dbg_cnt = 0;
    logic dbg_prev = 1'b0;
    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];
    for (genvar m = 0; m < 4; m++) begin : g
        wire mw;
        pulldown (mw);
        assign miso[m] = mw;
        spi_slave_stream #(
            .DATA_WIDTH(8), .RX_DEPTH(4), .TX_DEPTH(4),
            .CPOL(m / 2 == 1), .CPHA(m % 2 == 1)
        ) dut (
            .clock(clock), .reset(reset), .spi_clk(sclk[m]), .spi_cs(cs[m]), .mosi(mosi[m]),
            .miso(mw), .rx_data(rx_data[m]), .rx_valid(rx_valid[m]), .rx_ready(rx_ready[m]),
            .rx_level(rx_level[m]), .tx_data(tx_data[m]), .tx_wr(tx_wr[m]), .tx_full(tx_full[m]),
            .tx_level(tx_level[m]), .status_clear(status_clear[m]), .rx_overrun(rx_overrun[m]),
            .tx_underrun(tx_underrun[m]), .frame_done(frame_done[m]), .frame_abort(frame_abort[m]),
            .debug_word(debug_word[m])
        );
    end
    always @(negedge clock) begin
        if (frame_done[0]) done_cnt++;
        if (frame_abort[0]) abort_cnt++;
        if (frame_done[0] && frame_abort[0]) both_cnt++;
        if (debug_word[0] !== dbg_prev) dbg_cnt++;
        dbg_prev = debug_word[0];
    end
    task automatic clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic push_tx(input int m, input logic [7:0] d);
        tx_data[m] = d;
        tx_wr[m] = 1'b1;
        clks(1);
        tx_wr[m] = 1'b0;
    endtask
    task automatic pulse_clear(input int m);
        status_clear[m] = 1'b1;
        clks(1);
        status_clear[m] = 1'b0;
    endtask
    task automatic cs_low(input int m);
        cs[m] = 1'b0;
        clks(H);
    endtask
    task automatic cs_high(input int m);
        clks(H);
        cs[m] = 1'b1;
        clks(H);
    endtask
    task automatic xfer(input int m, input logic [7:0] mo, input int nbits, input bit pop_at_push,
                        output logic [7:0] mi, output logic [7:0] popped);
        logic cpol, cpha;
        cpol = (m / 2) == 1;
        cpha = (m % 2) == 1;
        mi = '0;
        popped = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (cpha) sclk[m] = ~cpol;
            mosi[m] = mo[i];
            clks(H);
            mi[i] = miso[m];
            sclk[m] = cpha ? cpol : ~cpol;
            if (pop_at_push && i == 0) begin
                clks(2);
                rx_ready[m] = 1'b1;
                popped = rx_data[m];
                clks(1);
                rx_ready[m] = 1'b0;
                clks(H - 3);
            end else begin
                clks(H);
            end
            if (!cpha) sclk[m] = cpol;
        end
    endtask
    task automatic pop_rx(input int m, output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d = '0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (rx_valid[m]) ok = 1'b1;
            else clks(1);
        end
        if (ok) begin
            d = rx_data[m];
            rx_ready[m] = 1'b1;
            clks(1);
            rx_ready[m] = 1'b0;
        end
    endtask
    task automatic test_reset;
        reset = 1'b1;
        clks(2);
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (rx_valid[m] !== 1'b0 || rx_level[m] !== 3'd0 || rx_data[m] !== 8'h00 || tx_level[m] !== 3'd0 || tx_full[m] !== 1'b0) begin
                errors++;
                $display("FAIL reset_fifo[%0d] got rv=%b rl=%0d rd=%h tl=%0d tf=%b want 0", m, rx_valid[m], rx_level[m], rx_data[m], tx_level[m], tx_full[m]);
            end
            checks++;
            if ({rx_overrun[m], tx_underrun[m], frame_done[m], frame_abort[m], debug_word[m]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_flags[%0d] got %b want 00000", m, {rx_overrun[m], tx_underrun[m], frame_done[m], frame_abort[m], debug_word[m]});
            end
            checks++;
            if (miso[m] !== 1'b0) begin
                errors++;
                $display("FAIL reset_miso_z[%0d] got %b want 0 (undriven, pulled down)", m, miso[m]);
            end
        end
        reset = 1'b0;
        clks(4);
    endtask
    task automatic test_mode0;
        logic [7:0] mi, pd, d, exp;
        bit ok;
        int d0, a0, g0;
        push_tx(0, 8'h81);
        tx_q.push_back(8'h81);
        push_tx(0, 8'h42);
        tx_q.push_back(8'h42);
        checks++;
        if (tx_level[0] !== 3'd2) begin errors++; $display("FAIL m0_tx_level got %0d want 2", tx_level[0]); end
        d0 = done_cnt; a0 = abort_cnt; g0 = dbg_cnt;
        cs_low(0);
        foreach (tx_q[k]) begin end
        xfer(0, 8'hA5, 8, 1'b0, mi, pd);
        rx_q.push_back(8'hA5);
        exp = tx_q.pop_front();
        checks++;
        if (mi !== exp) begin errors++; $display("FAIL m0_miso_w0 got %h want %h", mi, exp); end
        xfer(0, 8'h3C, 8, 1'b0, mi, pd);
        rx_q.push_back(8'h3C);
        exp = tx_q.pop_front();
        checks++;
        if (mi !== exp) begin errors++; $display("FAIL m0_miso_w1 got %h want %h", mi, exp); end
        cs_high(0);
        checks++;
        if (rx_level[0] !== 3'd2) begin errors++; $display("FAIL m0_rx_level got %0d want 2", rx_level[0]); end
        checks++;
        if (done_cnt - d0 != 1 || abort_cnt - a0 != 0) begin errors++; $display("FAIL m0_frame got done=%0d abort=%0d want 1 0", done_cnt - d0, abort_cnt - a0); end
        checks++;
        if (dbg_cnt - g0 != 2) begin errors++; $display("FAIL m0_debug_toggles got %0d want 2", dbg_cnt - g0); end
        while (rx_q.size() > 0) begin
            exp = rx_q.pop_front();
            pop_rx(0, d, ok);
            checks++;
            if (!ok || d !== exp) begin errors++; $display("FAIL m0_rx_pop got %h ok=%0d want %h", d, ok, exp); end
        end
        pulse_clear(0);
    endtask
    task automatic test_modes;
        logic [7:0] mi, pd, d, exp;
        bit ok;
        for (int m = 1; m < 4; m++) begin
            push_tx(m, 8'hC3);
            tx_q.push_back(8'hC3);
            cs_low(m);
            xfer(m, 8'h5A, 8, 1'b0, mi, pd);
            rx_q.push_back(8'h5A);
            cs_high(m);
            exp = tx_q.pop_front();
            checks++;
            if (mi !== exp) begin errors++; $display("FAIL mode%0d_miso got %h want %h", m, mi, exp); end
            exp = rx_q.pop_front();
            pop_rx(m, d, ok);
            checks++;
            if (!ok || d !== exp) begin errors++; $display("FAIL mode%0d_rx got %h ok=%0d want %h", m, d, ok, exp); end
        end
    endtask
    task automatic test_underrun;
        logic [7:0] mi, pd, d, exp;
        bit ok;
        pulse_clear(0);
        checks++;
        if (tx_underrun[0] !== 1'b0) begin errors++; $display("FAIL und_cleared0 got %b want 0", tx_underrun[0]); end
        cs_low(0);
        tx_q.push_back(8'hFF);
        xfer(0, 8'h11, 8, 1'b0, mi, pd);
        rx_q.push_back(8'h11);
        cs_high(0);
        exp = tx_q.pop_front();
        checks++;
        if (mi !== exp) begin errors++; $display("FAIL und_idle got %h want %h", mi, exp); end
        checks++;
        if (tx_underrun[0] !== 1'b1) begin errors++; $display("FAIL und_set got %b want 1", tx_underrun[0]); end
        exp = rx_q.pop_front();
        pop_rx(0, d, ok);
        checks++;
        if (!ok || d !== exp) begin errors++; $display("FAIL und_rx got %h ok=%0d want %h", d, ok, exp); end
        pulse_clear(0);
        checks++;
        if (tx_underrun[0] !== 1'b0) begin errors++; $display("FAIL und_clear got %b want 0", tx_underrun[0]); end
        cs[0] = 1'b0;
        clks(2);
        status_clear[0] = 1'b1;
        clks(1);
        status_clear[0] = 1'b0;
        checks++;
        if (tx_underrun[0] !== 1'b1) begin errors++; $display("FAIL und_set_wins got %b want 1", tx_underrun[0]); end
        clks(H - 3);
        tx_q.push_back(8'hFF);
        xfer(0, 8'h22, 8, 1'b0, mi, pd);
        rx_q.push_back(8'h22);
        cs_high(0);
        exp = tx_q.pop_front();
        checks++;
        if (mi !== exp) begin errors++; $display("FAIL und_idle2 got %h want %h", mi, exp); end
        exp = rx_q.pop_front();
        pop_rx(0, d, ok);
        checks++;
        if (!ok || d !== exp) begin errors++; $display("FAIL und_rx2 got %h ok=%0d want %h", d, ok, exp); end
        pulse_clear(0);
    endtask
    task automatic test_overrun;
        logic [7:0] mi, pd, d, exp;
        bit ok;
        cs_low(0);
        for (int b = 1; b <= 5; b++) begin
            xfer(0, 8'(b), 8, 1'b0, mi, pd);
            if (b <= 4) rx_q.push_back(8'(b));
        end
        cs_high(0);
        checks++;
        if (rx_level[0] !== 3'd4) begin errors++; $display("FAIL ovr_level got %0d want 4", rx_level[0]); end
        checks++;
        if (rx_overrun[0] !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", rx_overrun[0]); end
        while (rx_q.size() > 0) begin
            exp = rx_q.pop_front();
            pop_rx(0, d, ok);
            checks++;
            if (!ok || d !== exp) begin errors++; $display("FAIL ovr_pop got %h ok=%0d want %h", d, ok, exp); end
        end
        pulse_clear(0);
        checks++;
        if (rx_overrun[0] !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", rx_overrun[0]); end
        cs_low(0);
        for (int b = 1; b <= 5; b++) begin
            xfer(0, 8'(b), 8, b == 5, mi, pd);
            rx_q.push_back(8'(b));
            if (b == 5) begin
                exp = rx_q.pop_front();
                checks++;
                if (pd !== exp) begin errors++; $display("FAIL ovr_pop_on_push got %h want %h", pd, exp); end
            end
        end
        cs_high(0);
        checks++;
        if (rx_level[0] !== 3'd4 || rx_overrun[0] !== 1'b0) begin errors++; $display("FAIL ovr_nodrop got level=%0d ovr=%b want 4 0", rx_level[0], rx_overrun[0]); end
        while (rx_q.size() > 0) begin
            exp = rx_q.pop_front();
            pop_rx(0, d, ok);
            checks++;
            if (!ok || d !== exp) begin errors++; $display("FAIL ovr_pop2 got %h ok=%0d want %h", d, ok, exp); end
        end
        pulse_clear(0);
    endtask
    task automatic test_abort;
        logic [7:0] mi, pd, d, exp;
        bit ok;
        int d0, a0, b0, g0;
        d0 = done_cnt; a0 = abort_cnt; b0 = both_cnt; g0 = dbg_cnt;
        cs_low(0);
        xfer(0, 8'hE0, 5, 1'b0, mi, pd);
        cs_high(0);
        checks++;
        if (done_cnt - d0 != 1 || abort_cnt - a0 != 1 || both_cnt - b0 != 1) begin
            errors++;
            $display("FAIL abort_pulse got done=%0d abort=%0d together=%0d want 1 1 1", done_cnt - d0, abort_cnt - a0, both_cnt - b0);
        end
        checks++;
        if (rx_level[0] !== 3'd0 || dbg_cnt != g0) begin errors++; $display("FAIL abort_nopush got level=%0d toggles=%0d want 0 0", rx_level[0], dbg_cnt - g0); end
        push_tx(0, 8'h3E);
        tx_q.push_back(8'h3E);
        cs_low(0);
        xfer(0, 8'h77, 8, 1'b0, mi, pd);
        rx_q.push_back(8'h77);
        cs_high(0);
        exp = tx_q.pop_front();
        checks++;
        if (mi !== exp) begin errors++; $display("FAIL abort_next_miso got %h want %h", mi, exp); end
        checks++;
        if (abort_cnt - a0 != 1) begin errors++; $display("FAIL abort_next_clean got aborts=%0d want 1", abort_cnt - a0); end
        exp = rx_q.pop_front();
        pop_rx(0, d, ok);
        checks++;
        if (!ok || d !== exp) begin errors++; $display("FAIL abort_next_rx got %h ok=%0d want %h", d, ok, exp); end
        pulse_clear(0);
    endtask
    task automatic test_reset_mid;
        logic [7:0] mi, pd, d, exp;
        bit ok;
        cs_low(0);
        xfer(0, 8'h12, 8, 1'b0, mi, pd);
        xfer(0, 8'h34, 8, 1'b0, mi, pd);
        cs_high(0);
        push_tx(0, 8'hAA);
        push_tx(0, 8'hBB);
        checks++;
        if (rx_level[0] !== 3'd2 || tx_level[0] !== 3'd2) begin errors++; $display("FAIL rst_pre got rl=%0d tl=%0d want 2 2", rx_level[0], tx_level[0]); end
        cs_low(0);
        xfer(0, 8'hF0, 3, 1'b0, mi, pd);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (rx_valid[0] !== 1'b0 || rx_level[0] !== 3'd0 || rx_data[0] !== 8'h00 || tx_level[0] !== 3'd0 || tx_full[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_fifo got rv=%b rl=%0d rd=%h tl=%0d tf=%b want 0", rx_valid[0], rx_level[0], rx_data[0], tx_level[0], tx_full[0]);
        end
        checks++;
        if ({rx_overrun[0], tx_underrun[0], frame_done[0], frame_abort[0], debug_word[0]} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_flags got %b want 00000", {rx_overrun[0], tx_underrun[0], frame_done[0], frame_abort[0], debug_word[0]});
        end
        checks++;
        if (miso[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_miso_z got %b want 0 (undriven, pulled down)", miso[0]); end
        cs[0] = 1'b1;
        sclk[0] = 1'b0;
        clks(4);
        reset = 1'b0;
        clks(2);
        push_tx(0, 8'h81);
        tx_q.push_back(8'h81);
        cs_low(0);
        xfer(0, 8'h96, 8, 1'b0, mi, pd);
        rx_q.push_back(8'h96);
        cs_high(0);
        exp = tx_q.pop_front();
        checks++;
        if (mi !== exp) begin errors++; $display("FAIL rst_after_miso got %h want %h", mi, exp); end
        exp = rx_q.pop_front();
        pop_rx(0, d, ok);
        checks++;
        if (!ok || d !== exp) begin errors++; $display("FAIL rst_after_rx got %h ok=%0d want %h", d, ok, exp); end
    endtask
    initial begin
        sclk = 4'b1100;
        cs = 4'hF;
        mosi = 4'h0;
        rx_ready = 4'h0;
        tx_wr = 4'h0;
        status_clear = 4'h0;
        for (int m = 0; m < 4; m++) tx_data[m] = 8'h00;
        test_reset();
        test_mode0();
        test_modes();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
